onchip_memory_pipelined: RTL and testbench

ONCHIP_MEMORY_PIPELINED -- requirements
Module: onchip_memory_pipelined

---
 rtl/onchip_memory_pipelined_pkg.sv | 6 +
 rtl/onchip_memory_pipelined_ram_sp_byteen.sv | 32 +++
 rtl/onchip_memory_pipelined.sv | 82 ++++++++
 tb/tb_onchip_memory_pipelined.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/onchip_memory_pipelined_pkg.sv
// onchip_memory_pipelined_pkg: shared state encoding and legal read-latency bounds
package onchip_memory_pipelined_pkg;
  typedef enum logic {ST_CLEAR, ST_READY} state_e;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;
endpackage

// File: rtl/onchip_memory_pipelined_ram_sp_byteen.sv
// ram_sp_byteen: single-port byte-enabled RAM with synchronous read, out-of-range writes dropped and reads returning zero
module ram_sp_byteen #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15,
  parameter int DEPTH      = 32000
) (
  input  logic                    clk,
  input  logic                    ce_i,
  input  logic                    we_i,
  input  logic                    re_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  in_range;
  logic [IW-1:0]         idx;
  assign in_range = {1'b0, addr_i} < DEPTH_W;
  assign idx = addr_i[IW-1:0];
  // lane-masked write and registered read, both frozen when ce_i is low
  always_ff @(posedge clk)
    if (ce_i) begin
      if (we_i && in_range)
        for (int b = 0; b < NB; b++)
          if (be_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      if (re_i) rdata_o <= in_range ? mem_q[idx] : '0;
    end
endmodule

// File: rtl/onchip_memory_pipelined.sv
// onchip_memory_pipelined: Avalon-MM on-chip RAM slave with zero-fill after reset and 1/2-cycle read latency
module onchip_memory_pipelined
  import onchip_memory_pipelined_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 15,
  parameter int DEPTH          = 32000,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  input  logic                    reset_req,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  en, clearing, acc, wr, rd;
  logic [DATA_WIDTH-1:0] ram_rdata, stg_q, last_q, out_data;
  logic                  v1_q, v2_q, vout;
  assign en = clken & ~reset_req;
  assign clearing = state_q == ST_CLEAR;
  assign waitrequest = reset | clearing | ~en;
  assign acc = chipselect & ~waitrequest;
  assign wr = acc & write;
  assign rd = acc & read & ~write;
  // clear sweep advances one word per enabled cycle and hands over to READY after the last word
  always_comb begin
    cnt_d = (clearing && en) ? cnt_q + 1'b1 : cnt_q;
    state_d = (clearing && en && cnt_q == LAST) ? ST_READY : state_q;
  end
  // state and clear-counter registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= CLEAR_ON_RESET != 0 ? ST_CLEAR : ST_READY;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  ram_sp_byteen #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk    (clk),
    .ce_i   (en),
    .we_i   (clearing | wr),
    .re_i   (rd),
    .addr_i (clearing ? cnt_q : address),
    .be_i   (clearing ? '1 : byteenable),
    .wdata_i(clearing ? '0 : writedata),
    .rdata_o(ram_rdata)
  );
  assign vout = (READ_LATENCY == LAT_MAX ? v2_q : v1_q) & en;
  assign out_data = READ_LATENCY == LAT_MAX ? stg_q : ram_rdata;
  assign readdatavalid = vout;
  assign readdata = vout ? out_data : last_q;
  // read-valid pipeline, optional second data stage and held copy of the last delivered word
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      stg_q <= '0;
      last_q <= '0;
    end else if (en) begin
      v1_q <= rd;
      v2_q <= v1_q;
      stg_q <= ram_rdata;
      if (vout) last_q <= out_data;
    end
endmodule

// File: tb/tb_onchip_memory_pipelined.sv
// tb_onchip_memory_pipelined: random and directed checks of the memory slave against a behavioural model
module tb_onchip_memory_pipelined;
  logic        clk = 0, reset = 1, cs = 0, rd = 0, wr = 0, clken = 1, rreq = 0;
  logic [4:0]  addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wd = '0;
  logic [31:0] rdata1, rdata2, rdata3;
  logic        rdv1, rdv2, rdv3, wait1, wait2, wait3;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  onchip_memory_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .reset(reset), .address(addr), .byteenable(be), .chipselect(cs), .read(rd), .write(wr),
    .writedata(wd), .clken(clken), .reset_req(rreq), .readdata(rdata1), .readdatavalid(rdv1), .waitrequest(wait1));
  onchip_memory_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u2 (
    .clk(clk), .reset(reset), .address(addr), .byteenable(be), .chipselect(cs), .read(rd), .write(wr),
    .writedata(wd), .clken(clken), .reset_req(rreq), .readdata(rdata2), .readdatavalid(rdv2), .waitrequest(wait2));
  onchip_memory_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16), .READ_LATENCY(1), .CLEAR_ON_RESET(0)) u3 (
    .clk(clk), .reset(reset), .address(addr), .byteenable(be), .chipselect(cs), .read(rd), .write(wr),
    .writedata(wd), .clken(clken), .reset_req(rreq), .readdata(rdata3), .readdatavalid(rdv3), .waitrequest(wait3));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory array, words left to clear, count of enabled edges,
  // and a queue of accepted reads tagged with the enabled-edge count at acceptance.
  // A read accepted while the count is c is visible with latency L while the count equals c+L.
  typedef struct {logic [31:0] data; int c;} rq_t;
  rq_t         q[$];
  logic [31:0] mmem [16];
  int          clear_left = 16, ecnt = 0;
  logic [31:0] last1 = 0, last2 = 0, ed1, ed2, rdat;
  logic        m_en, ev1, ev2, exp_w, exp_w3;

  always @(negedge clk) begin
    if (reset) begin
      clear_left = 16;
      ecnt = 0;
      q.delete();
      last1 = 0;
      last2 = 0;
      for (int i = 0; i < 16; i++) mmem[i] = 0;
    end
    m_en = clken && !rreq;
    exp_w = reset || clear_left > 0 || !m_en;
    exp_w3 = reset || !m_en;
    ev1 = 0;
    ev2 = 0;
    ed1 = last1;
    ed2 = last2;
    foreach (q[j]) begin
      if (m_en && q[j].c + 1 == ecnt) begin ev1 = 1; ed1 = q[j].data; end
      if (m_en && q[j].c + 2 == ecnt) begin ev2 = 1; ed2 = q[j].data; end
    end
    last1 = ed1;
    last2 = ed2;
    chk("wait_l1", wait1, exp_w);
    chk("wait_l2", wait2, exp_w);
    chk("wait_noclear", wait3, exp_w3);
    chk("rdv_l1", rdv1, ev1);
    chk("rdv_l2", rdv2, ev2);
    chk("rdata_l1", rdata1, ed1);
    chk("rdata_l2", rdata2, ed2);
    if (!reset && m_en) begin
      if (clear_left > 0) clear_left--;
      else if (cs && wr) begin
        if (addr < 16)
          for (int b = 0; b < 4; b++)
            if (be[b]) mmem[addr[3:0]][8*b +: 8] = wd[8*b +: 8];
      end else if (cs && rd) begin
        rdat = addr < 16 ? mmem[addr[3:0]] : 32'h0;
        q.push_back('{rdat, ecnt});
      end
      ecnt++;
      while (q.size() > 0 && q[0].c + 2 < ecnt) void'(q.pop_front());
    end
  end

  task automatic cyc(input logic c, input logic r, input logic w, input logic [4:0] a, input logic [3:0] b, input logic [31:0] d);
    @(posedge clk);
    #1;
    cs = c; rd = r; wr = w; addr = a; be = b; wd = d;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic count_clear(input string name);
    int n = 0;
    @(negedge clk);
    while (wait1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, 16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  pat;
    logic [31:0] d2 [6];
    int          pulses;
    @(negedge clk);
    chk("rst_wait", wait1, 1);
    chk("rst_rdv", rdv2, 0);
    chk("rst_rdata", rdata2, 0);
    @(posedge clk);
    #1 reset = 0;
    count_clear("clear_len");
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 5'(i), 0, 0);
    idle();
    repeat (3) @(negedge clk);
    cyc(1, 0, 1, 3, 4'hf, 32'hDEADBEEF);
    cyc(1, 0, 1, 3, 4'h5, 32'h11223344);
    cyc(1, 1, 0, 3, 0, 0);
    idle();
    @(negedge clk);
    chk("be_merge_l1", {rdv1, rdata1}, {1'b1, 32'hDE22BE44});
    @(negedge clk);
    chk("be_merge_l2", {rdv2, rdata2}, {1'b1, 32'hDE22BE44});
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 5'(i), 4'hf, 32'hA0000000 + i);
    for (int i = 0; i < 6; i++) begin
      if (i < 3) cyc(1, 1, 0, 5'(i), 0, 0); else idle();
      @(negedge clk);
      pat[i] = rdv2;
      d2[i] = rdata2;
    end
    chk("l2_pattern", pat, 6'b011100);
    chk("l2_data0", d2[2], 32'hA0000000);
    chk("l2_data1", d2[3], 32'hA0000001);
    chk("l2_data2", d2[4], 32'hA0000002);
    cyc(1, 0, 1, 5, 4'hf, 32'hCAFEF00D);
    cyc(1, 1, 0, 5, 0, 0);
    @(posedge clk);
    #1;
    cs = 0; rd = 0; clken = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_rdv_l1", rdv1, 0);
      chk("hold_rdv_l2", rdv2, 0);
      chk("hold_wait", wait1, 1);
      if (i < 2) @(posedge clk);
    end
    @(posedge clk);
    #1 clken = 1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rdv1) begin
        pulses++;
        chk("hold_data", rdata1, 32'hCAFEF00D);
      end
    end
    chk("hold_pulses", pulses, 1);
    cyc(1, 0, 1, 4, 4'hf, 32'h00000044);
    cyc(1, 0, 1, 20, 4'hf, 32'h00000099);
    cyc(1, 1, 0, 4, 0, 0);
    idle();
    @(negedge clk);
    chk("oob_write_alias", {rdv1, rdata1}, {1'b1, 32'h00000044});
    cyc(1, 0, 1, 9, 4'hf, 32'hFFFFFFFF);
    idle();
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    repeat (7) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    count_clear("clear_restart");
    cyc(1, 1, 0, 16, 0, 0);
    idle();
    @(negedge clk);
    chk("oob_read", {rdv1, rdata1}, {1'b1, 32'h0});
    cyc(1, 1, 0, 9, 0, 0);
    idle();
    @(negedge clk);
    chk("cleared_word", {rdv1, rdata1}, {1'b1, 32'h0});
    repeat (600) begin
      @(posedge clk);
      #1;
      reset = $urandom_range(0, 99) == 0;
      clken = $urandom_range(0, 9) != 0;
      rreq = $urandom_range(0, 15) == 0;
      cs = $urandom_range(0, 3) != 0;
      rd = 1'($urandom);
      wr = 1'($urandom_range(0, 2) == 0);
      addr = 5'($urandom_range(0, 19));
      be = 4'($urandom);
      wd = $urandom;
    end
    @(posedge clk);
    #1;
    reset = 0; clken = 1; rreq = 0; cs = 0;
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
